serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
Parallel-in, serial-out framing transmitter; the sending end of the team's serial-serial shift-register link.
- Accepts one WIDTH-bit word through a valid/ready handshake.
- Emits the word on a single line as a frame: start bit (0), WIDTH data bits, stop bit (1).
- Bit order is selectable per frame, matching the receive-side leftright convention.
- Advances one symbol per clock edge on which enable is high.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  symbol tick / clock enable; state advances only on edges where enable=1
- data_in  input  WIDTH  parallel word to transmit
- load_valid  input  1  producer asserts while data_in/leftright are valid
- load_ready  output  1  high when a word can be accepted
- leftright  input  1  sampled at accept: 1 = MSB first (shift left), 0 = LSB first (shift right)
- out  output  1  serial line; idles high
- busy  output  1  high from the accept edge until the frame completes
- done  output  1  one-clock pulse at frame completion

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE, out=1, busy=0, done=0, shift register=0, counter=0.
  - Reset overrides enable and load_valid.
  - Reset mid-frame aborts the frame with no done pulse; out=1 from the next edge.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered except load_ready = (state==IDLE).
- Accept: at an edge where state==IDLE, load_valid=1 and enable=1:
  - latch data_in into the shift register and leftright into the direction flag.
  - counter<=0, out<=0, busy<=1, state<=START.
  - load_valid while not IDLE, or while enable=0, is ignored and no word is latched. The producer must hold load_valid until accepted.
- START, at an enable edge:
  - out<=first data bit (MSB if direction=1, else LSB).
  - shift register shifts one position; counter<=1; state<=DATA.
- DATA, at an enable edge:
  - If counter<WIDTH: out<=next bit, shift, counter++.
  - If counter==WIDTH: out<=1 (stop bit), state<=STOP.
- STOP, at an enable edge:
  - state<=IDLE, busy<=0, done<=1 for exactly one clock.
  - out stays 1.
- done clears on the next clock edge regardless of enable.
- enable=0 freezes state, out, counter and the shift register; done still self-clears.
- Timing:
  - Every symbol lasts exactly one enable period.
  - A frame is WIDTH+2 enable periods, from the accept edge to the STOP→IDLE edge.
  - Back-to-back: a new word is accepted at the earliest enable edge after IDLE is re-entered. The gap is one enable period of idle-high.
- The direction flag cannot change mid-frame. data_in changes after accept have no effect.
- Counter never exceeds WIDTH; no wrap-around is reachable.

Decomposition:
- Shared package ss_link_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, STOP}.
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1, DIR_MSB_FIRST=1'b1.
  - The receiver reuses the same package.
- One natural sub-module: ss_shift_unit. It is a WIDTH-bit parallel-load bidirectional shift register with load, shift and dir inputs, and a serial bit output. The FSM and counter stay in serial_frame_tx.

Test Plan:
1. Reset, WIDTH=8, enable held 1: assert reset 3 cycles mid-idle → out=1, busy=0, done=0, load_ready=1 on the first edge after reset.
2. data_in=8'hA5, leftright=1, load_valid pulsed one enable edge → out sequence per enable edge: 0, 1,0,1,0,0,1,0,1, 1. done is high for exactly one clock after 10 enable periods; busy falls on that same edge.
3. data_in=8'hA5, leftright=0 → data bits 1,0,1,0,0,1,0,1 (LSB first), framed by 0 and 1.
4. enable asserted every 4th clock, data_in=8'h3C, MSB first → each symbol holds 4 clocks; total 40 clocks accept-to-done. done stays a single-clock pulse.
5. load_valid held high continuously with words 8'h01 then 8'hFF → second word accepted on the first enable edge after IDLE. Exactly one idle-high enable period sits between the stop bit and the next start bit. load_valid during busy does not disturb the frame.
6. Reset asserted while out carries data bit 4 of frame 8'h0F → next edge out=1, busy=0, no done pulse, load_ready=1. A subsequent frame transmits correctly.

Source files
------------

// File: rtl/ss_link_pkg.sv
// Shared definitions for the serial shift-register link (transmitter and receiver).
package ss_link_pkg;

    // Transmitter frame sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Line levels used to frame a word.
    localparam logic LINE_IDLE     = 1'b1;
    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;

    // Direction flag value meaning "MSB first, shift left".
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage : ss_link_pkg

// File: rtl/ss_shift_unit.sv
// WIDTH-bit parallel-load bidirectional shift register with a serial bit tap.
// The tap always presents the bit that goes out next in the selected direction.
module ss_shift_unit
    import ss_link_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    // Next register contents: a parallel load wins over a shift.
    always_comb begin
        // NOTE: the hold value is assigned first so every path writes sreg_d and no latch is inferred.
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            if (dir_i == DIR_MSB_FIRST) begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
        end
    end

    // Register update with synchronous clear.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge (synchronous); non-blocking assignment keeps all flops updating together.
        if (rst_i) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    // Serial tap: top bit when sending MSB first, bottom bit otherwise.
    assign bit_o = (dir_i == DIR_MSB_FIRST) ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule : ss_shift_unit

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out framing transmitter.
// Sends start bit (0), WIDTH data bits in the direction chosen at accept, then stop bit (1).
// Every state change is gated by the enable tick, except the done pulse which always self-clears.
module serial_frame_tx
    import ss_link_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             leftright,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH);

    tx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             out_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             shift_en;
    logic             ser_bit;

    // A word is taken only on an enable edge while idle.
    assign accept   = (state_q == IDLE) && load_valid && enable;

    // Shift once per emitted data bit: the first one in START, the rest while the counter runs.
    assign shift_en = enable &&
                      ((state_q == START) || ((state_q == DATA) && (cnt_q != CNT_LAST)));

    ss_shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk_i   (clock),
        .rst_i   (reset),
        .load_i  (accept),
        .shift_i (shift_en),
        .dir_i   (dir_q),
        .data_i  (data_in),
        .bit_o   (ser_bit)
    );

    // Frame sequencer: state, bit counter, direction flag and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            out_q   <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // The completion pulse lasts one clock whether or not enable is high.
            done_q <= 1'b0;
            if (enable) begin
                case (state_q)
                    IDLE: begin
                        if (load_valid) begin
                            dir_q   <= leftright;
                            cnt_q   <= '0;
                            out_q   <= START_BIT;
                            busy_q  <= 1'b1;
                            state_q <= START;
                        end
                    end
                    START: begin
                        out_q   <= ser_bit;
                        cnt_q   <= CNT_FIRST;
                        state_q <= DATA;
                    end
                    DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            out_q   <= STOP_BIT;
                            state_q <= STOP;
                        end else begin
                            out_q <= ser_bit;
                            cnt_q <= cnt_q + CNT_FIRST;
                        end
                    end
                    STOP: begin
                        out_q   <= LINE_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // NOTE: load_ready is decoded straight from the state register so a waiting producer is accepted on the first idle enable edge.
    assign load_ready = (state_q == IDLE);
    assign out        = out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : serial_frame_tx

// File: tb/tb_serial_frame_tx.sv
// Directed testbench for serial_frame_tx (WIDTH=8).
// Inputs change on the falling edge; outputs are observed on the falling edge after each rising edge.
module tb_serial_frame_tx;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             leftright;
    logic             out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;

    serial_frame_tx #(
        .WIDTH (WIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .leftright  (leftright),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts one comparison; a failing one is counted and reported.
    task automatic check(input bit ok, input string msg);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s", msg);
        end
    endtask

    // One rising edge, then settle at the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Sends one word with enable high on every period-th clock and checks every clock.
    task automatic run_frame(input logic [7:0] word, input logic dir, input int period,
                             input string tag);
        logic exp_sym [10];
        int   idx;
        int   accept_c;
        int   done_c;
        bit   finished;
        exp_sym[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_sym[i+1] = dir ? word[7-i] : word[i];
        end
        exp_sym[9] = 1'b1;
        idx        = -1;
        accept_c   = -1;
        done_c     = -1;
        finished   = 1'b0;
        data_in    = word;
        leftright  = dir;
        load_valid = 1'b1;
        for (int c = 0; c < period * 11 + 4 && !finished; c++) begin
            enable = ((c % period) == 0);
            tick();
            if (enable && done_c < 0) begin
                idx++;
                if (idx == 0) begin
                    accept_c   = c;
                    load_valid = 1'b0;
                    data_in    = ~word;
                    leftright  = ~dir;
                end
            end
            if (idx >= 0 && idx <= 9) begin
                check(out === exp_sym[idx],
                      $sformatf("%s symbol %0d clk %0d: out=%b expected %b",
                                tag, idx, c, out, exp_sym[idx]));
                check({busy, done, load_ready} === 3'b100,
                      $sformatf("%s flags symbol %0d clk %0d: busy/done/ready=%b expected 100",
                                tag, idx, c, {busy, done, load_ready}));
            end else if (idx == 10) begin
                if (done_c < 0) begin
                    done_c = c;
                    check({out, busy, done, load_ready} === 4'b1011,
                          $sformatf("%s completion: out/busy/done/ready=%b expected 1011",
                                    tag, {out, busy, done, load_ready}));
                    check(done_c - accept_c == period * 10,
                          $sformatf("%s frame length: %0d clocks expected %0d",
                                    tag, done_c - accept_c, period * 10));
                end else begin
                    check({out, busy, done} === 3'b100,
                          $sformatf("%s after done: out/busy/done=%b expected 100",
                                    tag, {out, busy, done}));
                    finished = 1'b1;
                end
            end
        end
        enable = 1'b1;
        check(finished,
              $sformatf("%s timeout: frame not completed, symbol index %0d expected 10", tag, idx));
    endtask

    // Reset held 3 cycles with enable and load_valid high; line must stay idle.
    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hA5;
        leftright  = 1'b1;
        tick();
        check({out, busy, done, load_ready} === 4'b1001,
              $sformatf("reset first edge: out/busy/done/ready=%b expected 1001",
                        {out, busy, done, load_ready}));
        tick();
        tick();
        check({out, busy, done, load_ready} === 4'b1001,
              $sformatf("reset held: out/busy/done/ready=%b expected 1001",
                        {out, busy, done, load_ready}));
        reset      = 1'b0;
        load_valid = 1'b0;
        tick();
        check({out, busy, done, load_ready} === 4'b1001,
              $sformatf("idle after reset: out/busy/done/ready=%b expected 1001",
                        {out, busy, done, load_ready}));
    endtask

    task automatic test_msb_first();
        run_frame(8'hA5, 1'b1, 1, "msb_first_A5");
    endtask

    task automatic test_lsb_first();
        run_frame(8'hA5, 1'b0, 1, "lsb_first_A5");
    endtask

    task automatic test_slow_enable();
        run_frame(8'h3C, 1'b1, 4, "slow_enable_3C");
    endtask

    // load_valid held high across two words: 01 then FF, MSB first, enable every clock.
    task automatic test_back_to_back();
        logic [7:0] w0;
        logic [7:0] w1;
        logic       exp_out [23];
        logic       exp_busy;
        logic       exp_done;
        w0 = 8'h01;
        w1 = 8'hFF;
        exp_out[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_out[i+1] = w0[7-i];
        exp_out[9]  = 1'b1;
        exp_out[10] = 1'b1;
        exp_out[11] = 1'b0;
        for (int i = 0; i < 8; i++) exp_out[i+12] = w1[7-i];
        exp_out[20] = 1'b1;
        exp_out[21] = 1'b1;
        exp_out[22] = 1'b1;
        enable     = 1'b1;
        load_valid = 1'b1;
        leftright  = 1'b1;
        data_in    = w0;
        for (int e = 0; e < 23; e++) begin
            tick();
            if (e == 0)  data_in    = w1;
            if (e == 11) load_valid = 1'b0;
            exp_busy = (e <= 9) || (e >= 11 && e <= 20);
            exp_done = (e == 10) || (e == 21);
            check(out === exp_out[e],
                  $sformatf("back_to_back out edge %0d: out=%b expected %b", e, out, exp_out[e]));
            check({busy, done, load_ready} === {exp_busy, exp_done, ~exp_busy},
                  $sformatf("back_to_back flags edge %0d: busy/done/ready=%b expected %b",
                            e, {busy, done, load_ready}, {exp_busy, exp_done, ~exp_busy}));
        end
    endtask

    // Reset while frame 0F (MSB first) is on data bit 4, then send a clean frame.
    task automatic test_reset_midframe();
        enable     = 1'b1;
        load_valid = 1'b1;
        leftright  = 1'b1;
        data_in    = 8'h0F;
        tick();
        load_valid = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        check({out, busy} === 2'b01,
              $sformatf("midframe bit4: out/busy=%b expected 01", {out, busy}));
        reset = 1'b1;
        tick();
        check({out, busy, done, load_ready} === 4'b1001,
              $sformatf("midframe reset: out/busy/done/ready=%b expected 1001",
                        {out, busy, done, load_ready}));
        reset = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            check({out, busy, done, load_ready} === 4'b1001,
                  $sformatf("after abort clk %0d: out/busy/done/ready=%b expected 1001",
                            e, {out, busy, done, load_ready}));
        end
        run_frame(8'h0F, 1'b1, 1, "after_abort_0F");
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        leftright  = 1'b0;
        data_in    = '0;
        @(negedge clock);
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_slow_enable();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_serial_frame_tx
